// File: rtl/axi_txn_limiter.sv
// AXI4+ATOP outstanding-transaction limiter: passes every channel through combinationally,
// gating only AR/AW/W handshakes so the downstream ID serializer never sees too many in flight.
module axi_txn_limiter #(
  parameter int AXI_ID_WIDTH   = 32'd0,
  parameter int AXI_ADDR_WIDTH = 32'd0,
  parameter int AXI_DATA_WIDTH = 32'd0,
  parameter int AXI_USER_WIDTH = 32'd0,
  parameter int MAX_RD_TXNS    = 32'd8,
  parameter int MAX_WR_TXNS    = 32'd8
) (
  input  logic                          aclk,
  input  logic                          rst,
  // slave port (upstream)
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,
  input  logic                          s_axi_awlock,
  input  logic [3:0]                    s_axi_awcache,
  input  logic [2:0]                    s_axi_awprot,
  input  logic [3:0]                    s_axi_awqos,
  input  logic [5:0]                    s_axi_awatop,
  input  logic [3:0]                    s_axi_awregion,
  input  logic [AXI_USER_WIDTH-1:0]     s_axi_awuser,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic [AXI_USER_WIDTH-1:0]     s_axi_wuser,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic [AXI_USER_WIDTH-1:0]     s_axi_buser,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,
  input  logic                          s_axi_arlock,
  input  logic [3:0]                    s_axi_arcache,
  input  logic [2:0]                    s_axi_arprot,
  input  logic [3:0]                    s_axi_arqos,
  input  logic [3:0]                    s_axi_arregion,
  input  logic [AXI_USER_WIDTH-1:0]     s_axi_aruser,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic [AXI_USER_WIDTH-1:0]     s_axi_ruser,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,
  // master port (downstream to the ID serializer)
  output logic [AXI_ID_WIDTH-1:0]       m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [7:0]                    m_axi_awlen,
  output logic [2:0]                    m_axi_awsize,
  output logic [1:0]                    m_axi_awburst,
  output logic                          m_axi_awlock,
  output logic [3:0]                    m_axi_awcache,
  output logic [2:0]                    m_axi_awprot,
  output logic [3:0]                    m_axi_awqos,
  output logic [5:0]                    m_axi_awatop,
  output logic [3:0]                    m_axi_awregion,
  output logic [AXI_USER_WIDTH-1:0]     m_axi_awuser,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                          m_axi_wlast,
  output logic [AXI_USER_WIDTH-1:0]     m_axi_wuser,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_bid,
  input  logic [1:0]                    m_axi_bresp,
  input  logic [AXI_USER_WIDTH-1:0]     m_axi_buser,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  output logic [AXI_ID_WIDTH-1:0]       m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arlock,
  output logic [3:0]                    m_axi_arcache,
  output logic [2:0]                    m_axi_arprot,
  output logic [3:0]                    m_axi_arqos,
  output logic [3:0]                    m_axi_arregion,
  output logic [AXI_USER_WIDTH-1:0]     m_axi_aruser,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]       m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic [AXI_USER_WIDTH-1:0]     m_axi_ruser,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  // status
  output logic [$clog2(MAX_RD_TXNS+1)-1:0] rd_outstanding,
  output logic [$clog2(MAX_WR_TXNS+1)-1:0] wr_outstanding,
  output logic                          idle
);

  localparam int RD_W = $clog2(MAX_RD_TXNS + 1);
  localparam int WR_W = $clog2(MAX_WR_TXNS + 1);
  localparam logic [RD_W-1:0] RD_MAX  = RD_W'(MAX_RD_TXNS);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(MAX_RD_TXNS - 1);
  localparam logic [WR_W-1:0] WR_MAX  = WR_W'(MAX_WR_TXNS);

  logic [RD_W-1:0] rd_cnt, rd_next;
  logic [WR_W-1:0] wr_cnt, wr_next, w_pending, wp_next;
  logic rd_ok, aw_ok, w_ok;
  logic ar_hs, aw_hs, aw_rd_hs, w_last_hs, r_last_hs, b_hs;

  // Payload pass-through
  assign m_axi_awid     = s_axi_awid;
  assign m_axi_awaddr   = s_axi_awaddr;
  assign m_axi_awlen    = s_axi_awlen;
  assign m_axi_awsize   = s_axi_awsize;
  assign m_axi_awburst  = s_axi_awburst;
  assign m_axi_awlock   = s_axi_awlock;
  assign m_axi_awcache  = s_axi_awcache;
  assign m_axi_awprot   = s_axi_awprot;
  assign m_axi_awqos    = s_axi_awqos;
  assign m_axi_awatop   = s_axi_awatop;
  assign m_axi_awregion = s_axi_awregion;
  assign m_axi_awuser   = s_axi_awuser;
  assign m_axi_wdata    = s_axi_wdata;
  assign m_axi_wstrb    = s_axi_wstrb;
  assign m_axi_wlast    = s_axi_wlast;
  assign m_axi_wuser    = s_axi_wuser;
  assign s_axi_bid      = m_axi_bid;
  assign s_axi_bresp    = m_axi_bresp;
  assign s_axi_buser    = m_axi_buser;
  assign s_axi_bvalid   = m_axi_bvalid;
  assign m_axi_bready   = s_axi_bready;
  assign m_axi_arid     = s_axi_arid;
  assign m_axi_araddr   = s_axi_araddr;
  assign m_axi_arlen    = s_axi_arlen;
  assign m_axi_arsize   = s_axi_arsize;
  assign m_axi_arburst  = s_axi_arburst;
  assign m_axi_arlock   = s_axi_arlock;
  assign m_axi_arcache  = s_axi_arcache;
  assign m_axi_arprot   = s_axi_arprot;
  assign m_axi_arqos    = s_axi_arqos;
  assign m_axi_arregion = s_axi_arregion;
  assign m_axi_aruser   = s_axi_aruser;
  assign s_axi_rid      = m_axi_rid;
  assign s_axi_rdata    = m_axi_rdata;
  assign s_axi_rresp    = m_axi_rresp;
  assign s_axi_rlast    = m_axi_rlast;
  assign s_axi_ruser    = m_axi_ruser;
  assign s_axi_rvalid   = m_axi_rvalid;
  assign m_axi_rready   = s_axi_rready;

  assign rd_ok = rd_cnt < RD_MAX;
  assign ar_hs = s_axi_arvalid & m_axi_arready & rd_ok;

  // A read-returning atomic yields to a same-cycle AR when only one read slot is
  // left, so the two increments together can never push rd_cnt past its maximum.
  assign aw_ok = (wr_cnt < WR_MAX) &
                 (!s_axi_awatop[5] | (rd_ok & !(ar_hs & (rd_cnt == RD_LAST))));
  assign aw_hs    = s_axi_awvalid & m_axi_awready & aw_ok;
  assign aw_rd_hs = aw_hs & s_axi_awatop[5];

  // W may only follow an AW that has already gone out or is going out this cycle.
  assign w_ok      = (w_pending != '0) | aw_hs;
  assign w_last_hs = s_axi_wvalid & m_axi_wready & w_ok & s_axi_wlast;
  assign r_last_hs = m_axi_rvalid & s_axi_rready & m_axi_rlast;
  assign b_hs      = m_axi_bvalid & s_axi_bready;

  assign m_axi_arvalid = s_axi_arvalid & rd_ok;
  assign s_axi_arready = m_axi_arready & rd_ok;
  assign m_axi_awvalid = s_axi_awvalid & aw_ok;
  assign s_axi_awready = m_axi_awready & aw_ok;
  assign m_axi_wvalid  = s_axi_wvalid & w_ok;
  assign s_axi_wready  = m_axi_wready & w_ok;

  // Net delta per counter; a decrement at zero (stale response after reset) is dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_next = rd_cnt + RD_W'(ar_hs) + RD_W'(aw_rd_hs);
    wr_next = wr_cnt + WR_W'(aw_hs);
    wp_next = w_pending + WR_W'(aw_hs);
    if (r_last_hs && (rd_next != '0)) rd_next = rd_next - RD_W'(1);
    if (b_hs && (wr_next != '0))      wr_next = wr_next - WR_W'(1);
    if (w_last_hs && (wp_next != '0)) wp_next = wp_next - WR_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge aclk) begin
    if (rst) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      w_pending <= '0;
    end else begin
      rd_cnt    <= rd_next;
      wr_cnt    <= wr_next;
      w_pending <= wp_next;
    end
  end

  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;
  assign idle = (rd_cnt == '0) & (wr_cnt == '0) & (w_pending == '0);

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Scoreboard bench for axi_txn_limiter: stimulus pushes expected forwarded beats into queues,
// a negedge monitor pops and compares them, and directed checks cover the counters and gates.
module tb_axi_txn_limiter;

  localparam int IW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int UW = 2;
  localparam int MAX_RD = 2;
  localparam int MAX_WR = 2;

  logic aclk = 1'b0;
  logic rst;
  always #5 aclk = ~aclk;

  logic [IW-1:0] s_axi_awid, s_axi_bid, s_axi_arid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen;
  logic [2:0]    s_axi_awsize, s_axi_arsize, s_axi_awprot, s_axi_arprot;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awlock, s_axi_arlock;
  logic [3:0]    s_axi_awcache, s_axi_arcache, s_axi_awqos, s_axi_arqos, s_axi_awregion, s_axi_arregion;
  logic [5:0]    s_axi_awatop;
  logic [UW-1:0] s_axi_awuser, s_axi_wuser, s_axi_buser, s_axi_aruser, s_axi_ruser;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic s_axi_rlast, s_axi_rvalid, s_axi_rready;

  logic [IW-1:0] m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awlock, m_axi_arlock;
  logic [3:0]    m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos, m_axi_awregion, m_axi_arregion;
  logic [5:0]    m_axi_awatop;
  logic [UW-1:0] m_axi_awuser, m_axi_wuser, m_axi_buser, m_axi_aruser, m_axi_ruser;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

  logic [$clog2(MAX_RD+1)-1:0] rd_outstanding;
  logic [$clog2(MAX_WR+1)-1:0] wr_outstanding;
  logic idle;

  axi_txn_limiter #(
    .AXI_ID_WIDTH(IW), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_USER_WIDTH(UW),
    .MAX_RD_TXNS(MAX_RD), .MAX_WR_TXNS(MAX_WR)
  ) dut (
    .aclk(aclk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
    .s_axi_awatop(s_axi_awatop), .s_axi_awregion(s_axi_awregion), .s_axi_awuser(s_axi_awuser),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wuser(s_axi_wuser), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_buser(s_axi_buser),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awatop(m_axi_awatop), .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .idle(idle)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] ar_q[$];
  logic [37:0]   aw_q[$];
  logic [32:0]   w_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: downstream beat with empty expectation queue at %0t", name, $time);
  endtask

  // Monitor: pops expected beats when the downstream handshake happens
  always @(negedge aclk) begin
    if (!rst) begin
      if (m_axi_arvalid && m_axi_arready) begin
        if (ar_q.size() == 0) unexpected("ar_extra");
        else check("ar_fwd", m_axi_araddr, ar_q.pop_front());
      end
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_q.size() == 0) unexpected("aw_extra");
        else check("aw_fwd", {m_axi_awatop, m_axi_awaddr}, aw_q.pop_front());
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_q.size() == 0) unexpected("w_extra");
        else check("w_fwd", {m_axi_wlast, m_axi_wdata}, w_q.pop_front());
      end
      if (s_axi_arvalid) check("ar_hs_match", s_axi_arvalid & s_axi_arready, m_axi_arvalid & m_axi_arready);
      if (s_axi_awvalid) check("aw_hs_match", s_axi_awvalid & s_axi_awready, m_axi_awvalid & m_axi_awready);
      if (s_axi_wvalid)  check("w_hs_match", s_axi_wvalid & s_axi_wready, m_axi_wvalid & m_axi_wready);
      if (m_axi_rvalid)  check("r_pass", {s_axi_rvalid, s_axi_rlast, s_axi_rdata, m_axi_rready},
                               {1'b1, m_axi_rlast, m_axi_rdata, s_axi_rready});
      if (m_axi_bvalid)  check("b_pass", {s_axi_bvalid, s_axi_bresp, m_axi_bready},
                               {1'b1, m_axi_bresp, s_axi_bready});
      check("rd_bound", rd_outstanding <= MAX_RD, 1);
      check("wr_bound", wr_outstanding <= MAX_WR, 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  rd_pend, b_pend, w_todo;
  logic ar_f, aw_f, w_f;

  initial begin
    {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock} = '0;
    {s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awatop, s_axi_awregion, s_axi_awuser} = '0;
    {s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wuser, s_axi_wvalid, s_axi_awvalid} = '0;
    {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arlock} = '0;
    {s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion, s_axi_aruser, s_axi_arvalid} = '0;
    {m_axi_bid, m_axi_bresp, m_axi_buser, m_axi_bvalid} = '0;
    {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser, m_axi_rvalid} = '0;
    s_axi_wstrb = '1;
    s_axi_bready = 1'b1;
    s_axi_rready = 1'b0;
    m_axi_arready = 1'b1;
    m_axi_awready = 1'b1;
    m_axi_wready = 1'b1;
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    s_axi_wvalid = 1'b1;
    s_axi_wdata = 32'hdead;
    @(negedge aclk);
    check("reset_rd", rd_outstanding, 0);
    check("reset_wr", wr_outstanding, 0);
    check("reset_idle", idle, 1);
    check("reset_w_blocked", m_axi_wvalid, 0);
    step();
    s_axi_wvalid = 1'b0;

    // Read limit: third AR held until the first rlast handshake
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h1000; ar_q.push_back(32'h1000);
    @(negedge aclk); check("t1_ar1_pass", m_axi_arvalid, 1);
    step(); s_axi_araddr = 32'h1004; ar_q.push_back(32'h1004);
    @(negedge aclk); check("t1_ar2_pass", m_axi_arvalid, 1);
    step(); s_axi_araddr = 32'h1008; ar_q.push_back(32'h1008);
    @(negedge aclk);
    check("t1_rd_full", rd_outstanding, 2);
    check("t1_ar3_blocked", m_axi_arvalid, 0);
    repeat (3) begin
      step();
      @(negedge aclk); check("t1_ar3_held", m_axi_arvalid, 0);
    end
    step(); m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; s_axi_rready = 1'b1;
    @(negedge aclk); check("t1_held_in_dec_cycle", m_axi_arvalid, 0);
    step(); m_axi_rvalid = 1'b0;
    @(negedge aclk);
    check("t1_rd_after_rlast", rd_outstanding, 1);
    check("t1_ar3_released", m_axi_arvalid, 1);
    step(); s_axi_arvalid = 1'b0;
    @(negedge aclk); check("t1_rd_full_again", rd_outstanding, 2);
    m_axi_rvalid = 1'b1;
    repeat (2) step();
    m_axi_rvalid = 1'b0;
    @(negedge aclk); check("t1_drained", rd_outstanding, 0);

    // Same-cycle AR + rlast at rd_cnt=1, then atomic AW + AR at rd_cnt=0
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h2000; ar_q.push_back(32'h2000);
    step(); s_axi_araddr = 32'h2004; ar_q.push_back(32'h2004); m_axi_rvalid = 1'b1;
    @(negedge aclk); check("t2_rd_one", rd_outstanding, 1);
    step(); s_axi_arvalid = 1'b0; m_axi_rvalid = 1'b0;
    @(negedge aclk); check("t2_net_zero", rd_outstanding, 1);
    m_axi_rvalid = 1'b1;
    step(); m_axi_rvalid = 1'b0;
    @(negedge aclk); check("t2_rd_zero", rd_outstanding, 0);
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h3000; s_axi_awatop = 6'b100000;
    aw_q.push_back({6'b100000, 32'h3000});
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h2008; ar_q.push_back(32'h2008);
    step(); s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0; s_axi_awatop = '0;
    @(negedge aclk);
    check("t2_atomic_rd", rd_outstanding, 2);
    check("t2_atomic_wr", wr_outstanding, 1);
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h3100; s_axi_wlast = 1'b1; w_q.push_back({1'b1, 32'h3100});
    step(); s_axi_wvalid = 1'b0; m_axi_bvalid = 1'b1;
    step(); m_axi_bvalid = 1'b0; m_axi_rvalid = 1'b1;
    repeat (2) step();
    m_axi_rvalid = 1'b0;
    @(negedge aclk);
    check("t2_idle", idle, 1);
    check("t2_wr_zero", wr_outstanding, 0);

    // W presented three cycles ahead of its AW
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h4000; s_axi_wlast = 1'b0;
    for (int i = 0; i < 4; i++) w_q.push_back({(i == 3), 32'h4000 + 32'(i)});
    repeat (3) begin
      @(negedge aclk); check("t3_w_held", m_axi_wvalid, 0);
      step();
    end
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h5000; aw_q.push_back({6'b0, 32'h5000});
    for (int i = 0; i < 4; i++) begin
      s_axi_wdata = 32'h4000 + 32'(i);
      s_axi_wlast = (i == 3);
      @(negedge aclk); check("t3_w_fwd_valid", m_axi_wvalid, 1);
      step();
      s_axi_awvalid = 1'b0;
    end
    s_axi_wvalid = 1'b0;
    @(negedge aclk);
    check("t3_wr_one", wr_outstanding, 1);
    check("t3_not_idle", idle, 0);
    m_axi_bvalid = 1'b1;
    step(); m_axi_bvalid = 1'b0;
    @(negedge aclk); check("t3_idle", idle, 1);

    // Write limit: third AW blocked while B is withheld; B + AW in one cycle nets zero
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h4100; s_axi_wlast = 1'b1; w_q.push_back({1'b1, 32'h4100});
    @(negedge aclk); check("t4_w_closed", m_axi_wvalid, 0);
    step();
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h6000; aw_q.push_back({6'b0, 32'h6000});
    step(); s_axi_wvalid = 1'b0; s_axi_awaddr = 32'h6004; aw_q.push_back({6'b0, 32'h6004});
    step(); s_axi_awaddr = 32'h6008; aw_q.push_back({6'b0, 32'h6008});
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h4200; w_q.push_back({1'b1, 32'h4200});
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("t4_aw_blocked", m_axi_awvalid, 0);
      check("t4_wr_full", wr_outstanding, 2);
      step();
      s_axi_wvalid = 1'b0;
    end
    m_axi_bvalid = 1'b1;
    @(negedge aclk); check("t4_blocked_in_b_cycle", m_axi_awvalid, 0);
    step();
    @(negedge aclk);
    check("t4_aw_released", m_axi_awvalid, 1);
    check("t4_wr_after_b", wr_outstanding, 1);
    step(); s_axi_awvalid = 1'b0; m_axi_bvalid = 1'b0;
    @(negedge aclk); check("t4_net_zero", wr_outstanding, 1);
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h4300; w_q.push_back({1'b1, 32'h4300});
    step(); s_axi_wvalid = 1'b0; m_axi_bvalid = 1'b1;
    step(); m_axi_bvalid = 1'b0; s_axi_wlast = 1'b0;
    @(negedge aclk);
    check("t4_idle", idle, 1);

    // Mid-operation reset, then stale rlast beats must not underflow
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h7000; ar_q.push_back(32'h7000);
    step(); s_axi_araddr = 32'h7004; ar_q.push_back(32'h7004);
    step(); s_axi_arvalid = 1'b0;
    @(negedge aclk); check("t5_rd_before_reset", rd_outstanding, 2);
    rst = 1'b1;
    step();
    @(negedge aclk);
    check("t5_rd_reset", rd_outstanding, 0);
    check("t5_idle_reset", idle, 1);
    rst = 1'b0; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      check("t5_stale_rd", rd_outstanding, 0);
      check("t5_stale_idle", idle, 1);
      step();
    end
    m_axi_rvalid = 1'b0;

    // Constrained random traffic with a simple downstream responder
    rd_pend = 0; b_pend = 0; w_todo = 0;
    s_axi_rready = 1'b1; s_axi_bready = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      @(negedge aclk);
      ar_f = s_axi_arvalid & s_axi_arready;
      aw_f = s_axi_awvalid & s_axi_awready;
      w_f  = s_axi_wvalid & s_axi_wready;
      if (m_axi_arvalid && m_axi_arready) rd_pend++;
      if (m_axi_awvalid && m_axi_awready && m_axi_awatop[5]) rd_pend++;
      if (m_axi_wvalid && m_axi_wready && m_axi_wlast) b_pend++;
      if (m_axi_rvalid && m_axi_rready) rd_pend--;
      if (m_axi_bvalid && m_axi_bready) b_pend--;
      if (c >= 500 && !s_axi_arvalid && !s_axi_awvalid && !s_axi_wvalid && !m_axi_rvalid &&
          !m_axi_bvalid && rd_pend == 0 && b_pend == 0 && w_todo == 0) break;
      step();
      if (ar_f) s_axi_arvalid = 1'b0;
      if (!s_axi_arvalid && c < 500 && $urandom_range(0, 2) == 0) begin
        s_axi_araddr = $urandom; s_axi_arvalid = 1'b1; ar_q.push_back(s_axi_araddr);
      end
      if (aw_f) s_axi_awvalid = 1'b0;
      if (!s_axi_awvalid && c < 500 && $urandom_range(0, 2) == 0) begin
        s_axi_awaddr = $urandom;
        case ($urandom_range(0, 3))
          0:       s_axi_awatop = 6'b100000;
          1:       s_axi_awatop = 6'b010000;
          default: s_axi_awatop = 6'b000000;
        endcase
        s_axi_awvalid = 1'b1; aw_q.push_back({s_axi_awatop, s_axi_awaddr}); w_todo++;
      end
      if (w_f) s_axi_wvalid = 1'b0;
      if (!s_axi_wvalid && w_todo > 0) begin
        s_axi_wdata = $urandom; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        w_q.push_back({1'b1, s_axi_wdata}); w_todo--;
      end
      m_axi_arready = 1'($urandom_range(0, 1));
      m_axi_awready = 1'($urandom_range(0, 1));
      m_axi_wready  = 1'($urandom_range(0, 1));
      m_axi_rdata   = $urandom;
      m_axi_rvalid  = (rd_pend > 0) && ($urandom_range(0, 1) == 1);
      m_axi_bresp   = 2'($urandom_range(0, 3));
      m_axi_bvalid  = (b_pend > 0) && ($urandom_range(0, 1) == 1);
    end
    @(negedge aclk);
    check("rand_idle", idle, 1);
    check("rand_ar_q_empty", ar_q.size(), 0);
    check("rand_aw_q_empty", aw_q.size(), 0);
    check("rand_w_q_empty", w_q.size(), 0);
    check("rand_rd_pend", rd_pend, 0);
    check("rand_b_pend", b_pend, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
